// File: rtl/s_aes_enc_iter.sv
// Iterative S-AES encryptor: accepts one block per handshake, computes one round per clock,
// and expands round keys on the fly. The ciphertext is held on a valid/ready output.
module s_aes_enc_iter #(
   parameter logic [7:0] RCON1 = 8'h80,
   parameter logic [7:0] RCON2 = 8'h30
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [15:0] Plain_Text,
   input  logic [15:0] Key,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [15:0] Cipher_Text,
   output logic        Busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, R1 = 2'd1, R2 = 2'd2, DONE = 2'd3} fsm_t;

   fsm_t        fsm_reg, fsm_next;
   logic [15:0] state_reg;
   logic [15:0] rkey_reg;
   logic [15:0] sub_state, shifted, mixed, k1, k2, round1, round2;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
         4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
         4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
         4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  default: y = 4'h7;
      endcase
      return y;
   endfunction

   // Multiply by x in GF(2^4), reduction polynomial x^4+x+1.
   function automatic logic [3:0] xtime(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [7:0] mix_col(input logic [7:0] c);
      logic [3:0] a, b;
      a = c[7:4];
      b = c[3:0];
      return {a ^ xtime(xtime(b)), xtime(xtime(a)) ^ b};
   endfunction

   function automatic logic [15:0] expand(input logic [15:0] k, input logic [7:0] rc);
      logic [7:0] g, wa, wb;
      g  = {sbox(k[3:0]), sbox(k[7:4])} ^ rc;
      wa = k[15:8] ^ g;
      wb = wa ^ k[7:0];
      return {wa, wb};
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_state[gi*4 +: 4] = sbox(state_reg[gi*4 +: 4]);
   end

   assign shifted = {sub_state[15:12], sub_state[3:0], sub_state[7:4], sub_state[11:8]};
   assign mixed   = {mix_col(shifted[15:8]), mix_col(shifted[7:0])};
   assign k1      = expand(rkey_reg, RCON1);
   assign k2      = expand(rkey_reg, RCON2);
   assign round1  = mixed ^ k1;
   assign round2  = shifted ^ k2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fsm_reg <= IDLE;
      end else begin
         fsm_reg <= fsm_next;
      end
   end

   always_comb begin
      fsm_next = fsm_reg;
      case (fsm_reg)
         IDLE:    if (In_Valid) fsm_next = R1;
         R1:      fsm_next = R2;
         R2:      fsm_next = DONE;
         default: if (Out_Ready) fsm_next = IDLE;
      endcase
   end

   always_comb begin
      In_Ready  = (fsm_reg == IDLE);
      Out_Valid = (fsm_reg == DONE);
      Busy      = (fsm_reg != IDLE);
   end

   // Datapath: inputs are captured only on the accept edge; the last round also loads the output.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= 16'h0000;
         rkey_reg    <= 16'h0000;
         Cipher_Text <= 16'h0000;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (In_Valid) begin
                  state_reg <= Plain_Text ^ Key;
                  rkey_reg  <= Key;
               end
            end
            R1: begin
               state_reg <= round1;
               rkey_reg  <= k1;
            end
            R2: begin
               state_reg   <= round2;
               rkey_reg    <= k2;
               Cipher_Text <= round2;
            end
            default: ;
         endcase
      end
   end

endmodule
